// File: rtl/demux16_stream.sv
// demux16_stream: registered 1-to-2 word demultiplexer with valid/ready handshakes and per-channel beat counters
module demux16_stream #(
   parameter int W  = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  IN,
   input  logic          s,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  X,
   output logic          x_valid,
   input  logic          x_ready,
   output logic [W-1:0]  Y,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [CW-1:0] x_count,
   output logic [CW-1:0] y_count
);
   logic [W-1:0] xr, yr;
   logic xf, yf, x_pop, y_pop, x_load, y_load;
   assign x_pop = xf && x_ready;
   assign y_pop = yf && y_ready;
   assign X = xr;
   assign Y = yr;
   assign x_valid = xf;
   assign y_valid = yf;
   // readiness follows only the targeted channel, so a stalled target blocks the input
   always_comb begin
      in_ready = s ? (!yf || y_ready) : (!xf || x_ready);
      x_load = in_valid && in_ready && !s;
      y_load = in_valid && in_ready && s;
   end
   // holding registers refill on the same edge they are popped, counters count pops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr <= '0;
         yr <= '0;
         xf <= 1'b0;
         yf <= 1'b0;
         x_count <= '0;
         y_count <= '0;
      end else begin
         if (x_load) begin
            xr <= IN;
            xf <= 1'b1;
         end else if (x_pop) xf <= 1'b0;
         if (y_load) begin
            yr <= IN;
            yf <= 1'b1;
         end else if (y_pop) yf <= 1'b0;
         if (x_pop) x_count <= x_count + 1'b1;
         if (y_pop) y_count <= y_count + 1'b1;
      end
   end
endmodule

// File: doc/demux16_stream.md
# demux16_stream

Registered 16-bit 1-to-2 demultiplexer with valid/ready handshakes on one input and two output channels. Each accepted input word is steered by the `s` bit that travels with it: `s`=0 sends the word to channel X, `s`=1 to channel Y. This is the receive-side counterpart of the 16-bit 2:1 word multiplexer. It splits a shared 16-bit bus back into two independent consumers, for example an ALU result that goes either to the A register or to the data-memory write port. Each channel has a one-word holding register, per-channel beat counters and in-order delivery.

## Interface
- `W`, default 16: data width.
- `CW`, default 8: width of each per-channel beat counter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `IN`  in  W: input data word.
- `s`  in  1: steering bit, qualified by `in_valid`; 0 selects X, 1 selects Y.
- `in_valid`  in  1: the input word and `s` are valid.
- `in_ready`  out  1: the block accepts the input word this cycle.
- `X`  out  W: channel X data.
- `x_valid`  out  1: channel X holds a word.
- `x_ready`  in  1: the channel X consumer takes the word.
- `Y`  out  W: channel Y data.
- `y_valid`  out  1: channel Y holds a word.
- `y_ready`  in  1: the channel Y consumer takes the word.
- `x_count`  out  CW: number of words delivered on X, modulo 2^CW.
- `y_count`  out  CW: number of words delivered on Y, modulo 2^CW.

## Operation
- An input transfer happens when `in_valid` && `in_ready`. An output transfer on X happens when `x_valid` && `x_ready`; Y is handled the same way.
- Each channel has one holding register, `xr`/`yr`, and one full flag, `xf`/`yf`. `X`=`xr`, `x_valid`=`xf`, `Y`=`yr`, `y_valid`=`yf`.
- `in_ready` is combinational from `s`, the full flags and the output readies:
  - `s`=0: `in_ready` = !`xf` || `x_ready`.
  - `s`=1: `in_ready` = !`yf` || `y_ready`.
  - It never depends on the other channel's state.
- Input transfer with `s`=0: `xr`<=`IN` and `xf`<=1. The X output transfer in the same cycle, if any, pops the old word; the new word replaces it with no bubble. Y is handled the same way for `s`=1.
- Output transfer with no refill in the same cycle: the full flag is cleared to 0.
- `x_count` increments by 1 on each X output transfer and wraps from 2^CW-1 to 0. `y_count` behaves the same for Y.
- No reordering. A word for one channel never blocks the other channel's words that are already held.
- Head-of-line blocking is intended. An input word aimed at a stalled channel holds `in_ready` low, even if the other channel is empty.
- `s` and `IN` are don't-care when `in_valid`=0. `in_ready` may still toggle with `s`; the upstream side must not rely on `in_ready` while idle.
- The block never drops or duplicates a word.
- Data in `xr`/`yr` stays stable while the corresponding valid is high and ready is low.

## Timing
- Reset (`rst_n`=0, asynchronous assert, any time) forces the following immediately, with no clock needed:
  - `xf`=`yf`=0, so `x_valid`=`y_valid`=0.
  - `X`=`Y`=0.
  - `x_count`=`y_count`=0.
- Release of `rst_n` is synchronous to `clk`. The first transfer can occur on the first rising edge after release.
- A word held in a register when reset asserts is lost, not delivered.
- Latency is 1 cycle: a word accepted at edge n is presented with valid high after edge n.
- Throughput is 1 word per cycle, sustained, on alternating or repeated channels, provided the target consumer holds ready=1.
- Simultaneous input and output transfers on the same channel are a replace: full stays 1 and the count increments.
- Simultaneous output transfers on X and Y in one cycle are legal, and both counts increment.
- Counter wrap: at count 2^CW-1, one more transfer gives 0. There is no sticky overflow.

## Test plan
- Reset values:
  - Assert `rst_n`=0 mid-stream, with `xf`=1 and `X`=16'hBEEF → `x_valid`=0 and `X`=0 immediately, without a clock edge.
  - Both counts read 0.
  - After release, no stale word appears.
- Streaming alternation:
  - Send 16'h0001 with `s`=0, 16'h0002 with `s`=1, 16'h0003 with `s`=0 on consecutive cycles, with `x_ready`=`y_ready`=1.
  - Expect X=0001 at cycle 1, Y=0002 at cycle 2, X=0003 at cycle 3.
  - Expect `in_ready` held at 1 throughout, and finally `x_count`=2, `y_count`=1.
- Backpressure on the target channel:
  - Hold `x_ready`=0 and send 16'hAAAA with `s`=0, then 16'hBBBB with `s`=0.
  - Expect `in_ready`=0 on the second word and `X` stable at AAAA.
  - Raise `x_ready` for one cycle: AAAA is taken, BBBB is loaded on the same edge, and `x_count`=1.
- Head-of-line blocking:
  - With X stalled and holding a word, present a word with `s`=0 followed by one with `s`=1.
  - Expect the `s`=1 word not to be accepted until X drains.
  - Expect `y_valid` to stay 0 meanwhile.
- Independent drains: with both channels full, assert `x_ready`=`y_ready`=1 in one cycle → both valids fall and both counts increment by 1.
- Counter wrap (`CW`=8): deliver 256 words on Y → `y_count` reads 8'hFF after 255 words and 8'h00 after 256, and `x_count` is unchanged.
